// File: rtl/storage_arbiter.sv
// storage_arbiter: N-channel arbiter in front of the single-port matrix storage RAM.
// Registered one-hot grant with fixed-priority or round-robin selection, burst lock,
// and a read-tag pipeline that returns o_rvalid to the issuing channel.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req/i_lock/i_we [N_CH]   per-channel request, burst hold, write enable
//   i_addr [N_CH*AW]           packed per-channel addresses (channel k at [k*AW +: AW])
//   i_wdata [N_CH*DW]          packed per-channel write data
//   o_gnt/o_rvalid [N_CH]      registered one-hot grant, per-channel read-valid pulse
//   o_rdata [DW]               read data (pass-through of i_mem_rdata)
//   o_busy, o_owner [CW]       grant held, index of granted channel
//   o_mem_we/addr/wdata        storage request of the granted channel
//   i_mem_rdata [DW]           storage read data, MEM_LAT cycles after the address
module storage_arbiter #(
  parameter int unsigned N_CH    = 3,
  parameter int unsigned AW      = 9,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned RR_MODE = 0,
  localparam int unsigned CW     = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    i_req,
  input  logic [N_CH-1:0]    i_lock,
  input  logic [N_CH-1:0]    i_we,
  input  logic [N_CH*AW-1:0] i_addr,
  input  logic [N_CH*DW-1:0] i_wdata,
  output logic [N_CH-1:0]    o_gnt,
  output logic [N_CH-1:0]    o_rvalid,
  output logic [DW-1:0]      o_rdata,
  output logic               o_busy,
  output logic [CW-1:0]      o_owner,
  output logic               o_mem_we,
  output logic [AW-1:0]      o_mem_addr,
  output logic [DW-1:0]      o_mem_wdata,
  input  logic [DW-1:0]      i_mem_rdata
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic [N_CH-1:0] gnt_q, gnt_d;
  logic [CW-1:0]   owner_q, owner_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   rr_q, rr_d;
  logic [N_CH-1:0] rv_pipe_q [MEM_LAT];

  logic [N_CH-1:0] acc_c;
  logic [N_CH-1:0] rd_c;
  logic            release_c;
  logic            pick_found;
  logic [CW-1:0]   pick_idx;

  // Accepted accesses: owner with its request up; owner releases when req and lock are both low.
  assign acc_c     = gnt_q & i_req;
  assign rd_c      = acc_c & ~i_we;
  assign release_c = |(gnt_q & ~i_req & ~i_lock);

  // Candidate selection: round-robin searches from rr_q upward, then wraps to the lowest index.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    if (RR_MODE != 0) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        if (!pick_found && i_req[k] && (CW'(k) >= rr_q)) begin
          pick_found = 1'b1;
          pick_idx   = CW'(k);
        end
      end
    end
    for (int k = 0; k < int'(N_CH); k++) begin
      if (!pick_found && i_req[k]) begin
        pick_found = 1'b1;
        pick_idx   = CW'(k);
      end
    end
  end

  // Grant FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
    end
  end

  // Next state: re-arbitrate from IDLE or on release; release and new grant share one edge.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    rr_d    = rr_q;
    if ((state_q == IDLE) || release_c) begin
      if (pick_found) begin
        state_d = OWN;
        gnt_d   = N_CH'(1) << pick_idx;
        owner_d = pick_idx;
        busy_d  = 1'b1;
        rr_d    = (pick_idx == CW'(N_CH - 1)) ? '0 : pick_idx + CW'(1);
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        owner_d = '0;
        busy_d  = 1'b0;
      end
    end
  end

  // Storage request mux: zero unless the owner is issuing an access this cycle.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (acc_c[k]) begin
        o_mem_we    = i_we[k];
        o_mem_addr  = i_addr[k*AW +: AW];
        o_mem_wdata = i_wdata[k*DW +: DW];
      end
    end
  end

  // Read tags travel as one-hot channel vectors so in-flight reads survive grant changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_LAT); i++) rv_pipe_q[i] <= '0;
    end else begin
      rv_pipe_q[0] <= rd_c;
      for (int i = 1; i < int'(MEM_LAT); i++) rv_pipe_q[i] <= rv_pipe_q[i-1];
    end
  end

  assign o_gnt    = gnt_q;
  assign o_owner  = owner_q;
  assign o_busy   = busy_q;
  assign o_rvalid = rv_pipe_q[MEM_LAT-1];
  assign o_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_storage_arbiter.sv
// Bench for storage_arbiter: a fixed-priority instance (MEM_LAT=2) and a round-robin
// instance (MEM_LAT=3) share all stimulus and are both checked against a reference model.
module tb_storage_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, lock, we;
  logic [26:0] addr;
  logic [95:0] wdata;
  logic [31:0] mrd;

  logic [2:0]  gnt_a, rv_a, gnt_b, rv_b;
  logic [31:0] rdata_a, rdata_b, mwd_a, mwd_b;
  logic        busy_a, busy_b, mwe_a, mwe_b;
  logic [1:0]  owner_a, owner_b;
  logic [8:0]  maddr_a, maddr_b;

  always #5 clk = ~clk;

  storage_arbiter #(.N_CH(3), .AW(9), .DW(32), .MEM_LAT(2), .RR_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_lock(lock), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_gnt(gnt_a), .o_rvalid(rv_a), .o_rdata(rdata_a), .o_busy(busy_a),
    .o_owner(owner_a), .o_mem_we(mwe_a), .o_mem_addr(maddr_a), .o_mem_wdata(mwd_a),
    .i_mem_rdata(mrd));

  storage_arbiter #(.N_CH(3), .AW(9), .DW(32), .MEM_LAT(3), .RR_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_lock(lock), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_gnt(gnt_b), .o_rvalid(rv_b), .o_rdata(rdata_b), .o_busy(busy_b),
    .o_owner(owner_b), .o_mem_we(mwe_b), .o_mem_addr(maddr_b), .o_mem_wdata(mwd_b),
    .i_mem_rdata(mrd));

  typedef struct packed {
    logic [2:0]  gnt;
    logic [2:0]  rv;
    logic [31:0] rdata;
    logic        busy;
    logic [1:0]  owner;
    logic        mwe;
    logic [8:0]  maddr;
    logic [31:0] mwd;
  } obs_t;

  obs_t obs_a, obs_b;
  assign obs_a = {gnt_a, rv_a, rdata_a, busy_a, owner_a, mwe_a, maddr_a, mwd_a};
  assign obs_b = {gnt_b, rv_b, rdata_b, busy_b, owner_b, mwe_b, maddr_b, mwd_b};

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 = idle), rr pointer, and a time-indexed read-return schedule.
  int         own [2];
  int         rrp [2];
  logic [2:0] due [2][16];
  int         cyc = 0;

  function automatic int lat(int m);
    return (m == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      own[m] = -1;
      rrp[m] = 0;
      for (int s = 0; s < 16; s++) due[m][s] = 3'b000;
    end
  endtask

  function automatic int pick(int m, logic [2:0] r);
    if (m == 0) begin
      for (int k = 0; k < 3; k++) if (r[k]) return k;
    end else begin
      for (int i = 0; i < 3; i++) begin
        int c;
        c = (rrp[m] + i) % 3;
        if (r[c]) return c;
      end
    end
    return -1;
  endfunction

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      obs_t  o;
      int    e;
      logic  acc;
      string p;
      o   = (m == 0) ? obs_a : obs_b;
      e   = own[m];
      p   = (m == 0) ? "fx" : "rr";
      acc = (e >= 0) ? req[e] : 1'b0;
      chk({p, " gnt"},   32'(o.gnt),   (e >= 0) ? 32'(1 << e) : 32'd0);
      chk({p, " owner"}, 32'(o.owner), (e >= 0) ? 32'(e) : 32'd0);
      chk({p, " busy"},  32'(o.busy),  32'(e >= 0));
      chk({p, " mwe"},   32'(o.mwe),   acc ? 32'(we[e]) : 32'd0);
      chk({p, " maddr"}, 32'(o.maddr), acc ? 32'(addr[e*9 +: 9]) : 32'd0);
      chk({p, " mwdata"}, o.mwd,       acc ? wdata[e*32 +: 32] : 32'd0);
      chk({p, " rvalid"}, 32'(o.rv),   32'(due[m][cyc % 16]));
      chk({p, " rdata"}, o.rdata,      mrd);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int m = 0; m < 2; m++) begin
        int e;
        int p;
        e = own[m];
        due[m][cyc % 16] = 3'b000;
        if (e >= 0 && req[e] && !we[e]) due[m][(cyc + lat(m)) % 16][e] = 1'b1;
        if (e < 0 || (!req[e] && !lock[e])) begin
          p = pick(m, req);
          own[m] = p;
          if (p >= 0) rrp[m] = (p + 1) % 3;
        end
      end
    end
    cyc++;
  endtask

  // One clock: compare at negedge, advance model, then return just after the posedge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    req = 3'b000; lock = 3'b000; we = 3'b000; mrd = 32'd0;
    repeat (2) cycle();
    chk("rst fx gnt", 32'(gnt_a), 32'd0);
    chk("rst rr gnt", 32'(gnt_b), 32'd0);
    chk("rst fx rvalid", 32'(rv_a), 32'd0);
    chk("rst rr owner/busy/we", 32'({owner_b, busy_b, mwe_b}), 32'd0);
    chk("rst fx addr", 32'(maddr_a), 32'd0);
    chk("rst fx wdata", mwd_a, 32'd0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] we;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic       mwe;
  } vec_t;

  vec_t       tbl [10];
  logic [2:0] rr_req [7];
  logic [2:0] rr_gnt [7];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fixed-priority grant/hold/lock table, applied from reset on dut_a.
    tbl[0] = '{3'b110, 3'b000, 3'b000, 3'b010, 2'd1, 1'b0};
    tbl[1] = '{3'b110, 3'b000, 3'b010, 3'b010, 2'd1, 1'b1};
    tbl[2] = '{3'b100, 3'b000, 3'b000, 3'b100, 2'd2, 1'b0};
    tbl[3] = '{3'b101, 3'b000, 3'b100, 3'b100, 2'd2, 1'b1};
    tbl[4] = '{3'b001, 3'b000, 3'b000, 3'b001, 2'd0, 1'b0};
    tbl[5] = '{3'b000, 3'b001, 3'b000, 3'b001, 2'd0, 1'b0};
    tbl[6] = '{3'b010, 3'b001, 3'b000, 3'b001, 2'd0, 1'b0};
    tbl[7] = '{3'b010, 3'b000, 3'b010, 3'b010, 2'd1, 1'b1};
    tbl[8] = '{3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0};
    tbl[9] = '{3'b100, 3'b000, 3'b000, 3'b100, 2'd2, 1'b0};
    rr_req = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011};
    rr_gnt = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};

    rst_n = 1'b0;
    req = 3'b000; lock = 3'b000; we = 3'b000; mrd = 32'd0;
    addr  = {9'h1A3, 9'h0C7, 9'h055};
    wdata = {32'hA5A5_0002, 32'h5A5A_0001, 32'hC3C3_0000};
    model_reset();

    do_reset();
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req; lock = tbl[i].lock; we = tbl[i].we;
      cycle();
      chk($sformatf("tbl%0d gnt", i),   32'(gnt_a),   32'(tbl[i].gnt));
      chk($sformatf("tbl%0d owner", i), 32'(owner_a), 32'(tbl[i].owner));
      chk($sformatf("tbl%0d busy", i),  32'(busy_a),  32'(|tbl[i].gnt));
      chk($sformatf("tbl%0d mwe", i),   32'(mwe_a),   32'(tbl[i].mwe));
    end

    // Ch2 read of 0x05 returns DEADBEEF two cycles later on dut_a.
    req = 3'b100; lock = 3'b000; we = 3'b000; addr[18 +: 9] = 9'h05;
    #1;
    chk("rd2 addr", 32'(maddr_a), 32'h05);
    chk("rd2 we", 32'(mwe_a), 32'd0);
    cycle();
    chk("rd2 rvalid early", 32'(rv_a), 32'd0);
    req = 3'b000;
    cycle();
    mrd = 32'hDEAD_BEEF;
    #1;
    chk("rd2 rvalid", 32'(rv_a), 32'b100);
    chk("rd2 rdata", rdata_a, 32'hDEAD_BEEF);
    cycle();
    mrd = 32'd0;

    // Round-robin rotation 0,1,2,0 with no idle gap on dut_b.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      req = rr_req[i];
      cycle();
      chk($sformatf("rr%0d gnt", i), 32'(gnt_b), 32'(rr_gnt[i]));
      chk($sformatf("rr%0d busy", i), 32'(busy_b), 32'd1);
    end

    // Ch1 write, then lock-hold with req low while ch0 waits.
    do_reset();
    req = 3'b010;
    cycle();
    chk("lk gnt fx", 32'(gnt_a), 32'b010);
    chk("lk gnt rr", 32'(gnt_b), 32'b010);
    we = 3'b010; addr[9 +: 9] = 9'h10; wdata[32 +: 32] = 32'h12;
    #1;
    chk("lk wr we", 32'(mwe_a), 32'd1);
    chk("lk wr addr", 32'(maddr_a), 32'h10);
    chk("lk wr data", mwd_a, 32'h12);
    cycle();
    req = 3'b001; lock = 3'b010; we = 3'b000;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk($sformatf("lk%0d gnt fx", i), 32'(gnt_a), 32'b010);
      chk($sformatf("lk%0d gnt rr", i), 32'(gnt_b), 32'b010);
      chk($sformatf("lk%0d mwe", i), 32'(mwe_a), 32'd0);
    end
    lock = 3'b000;
    cycle();
    chk("lk drop fx", 32'(gnt_a), 32'b001);
    chk("lk drop rr", 32'(gnt_b), 32'b001);

    // Ch0 read in flight while the grant moves to ch2 (writing).
    we = 3'b000;
    cycle();
    req = 3'b100; we = 3'b100;
    cycle();
    chk("fl gnt fx", 32'(gnt_a), 32'b100);
    chk("fl gnt rr", 32'(gnt_b), 32'b100);
    chk("fl rvalid fx", 32'(rv_a), 32'b001);
    cycle();
    chk("fl rvalid rr", 32'(rv_b), 32'b001);
    chk("fl rvalid fx after", 32'(rv_a), 32'b000);
    cycle();
    chk("fl rvalid fx ch2", 32'(rv_a), 32'b000);
    chk("fl rvalid rr ch2", 32'(rv_b), 32'b000);

    // Reset with two reads in flight flushes them.
    do_reset();
    req = 3'b001;
    cycle();
    repeat (2) cycle();
    rst_n = 1'b0;
    model_reset();
    req = 3'b000;
    #1;
    chk("mrst gnt rr", 32'(gnt_b), 32'd0);
    chk("mrst rvalid rr", 32'(rv_b), 32'd0);
    chk("mrst rvalid fx", 32'(rv_a), 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("mrst%0d rvalid rr", i), 32'(rv_b), 32'd0);
      chk($sformatf("mrst%0d gnt rr", i), 32'(gnt_b), 32'd0);
    end

    // Randomised traffic against the model, with occasional resets.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) req[k] = ~req[k];
        lock[k] = ($urandom_range(0, 5) == 0);
        we[k]   = 1'($urandom_range(0, 1));
      end
      addr  = 27'($urandom);
      wdata = {$urandom, $urandom, $urandom};
      mrd   = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
